// File: rtl/arc4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arc4_pkg
// Description : Shared types and constants for the ARC4 encryption block.
// Revision    : 1.0
// ============================================================================
package arc4_pkg;

    localparam int KEY_BYTES = 3;
    localparam int MEM_DEPTH = 256;
    localparam int CNT_W     = 9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_KSA  = 3'd2,
        ST_LEN  = 3'd3,
        ST_PRGA = 3'd4,
        ST_DONE = 3'd5
    } arc4_state_e;

    typedef enum logic [2:0] {
        SW_IDLE = 3'd0,
        SW_RDI  = 3'd1,
        SW_RDJ  = 3'd2,
        SW_WRJ  = 3'd3,
        SW_WRI  = 3'd4
    } swap_state_e;

    // Sub-steps inside KSA/LEN/PRGA; LEN only uses START (read) and WAIT (write).
    typedef enum logic [1:0] {
        PH_START = 2'd0,
        PH_WAIT  = 2'd1,
        PH_PAD   = 2'd2,
        PH_WRITE = 2'd3
    } phase_e;

    function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = key[23:16];
            2'd1:    b = key[15:8];
            default: b = key[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arc4_encrypt_swap.sv
`default_nettype none
// ============================================================================
// Module      : arc4_swap
// Description : Read S[i], read S[j'] (j' = j + S[i] + add), write S[j'], write S[i].
// Revision    : 1.0
// ============================================================================
module arc4_swap
    import arc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] i_addr_i,
    input  logic [7:0] j_i,
    input  logic [7:0] add_i,
    input  logic [7:0] s_rddata_i,
    output logic [7:0] s_addr_o,
    output logic [7:0] s_wrdata_o,
    output logic       s_wren_o,
    output logic       done_o,
    output logic [7:0] j_o,
    output logic [7:0] si_o,
    output logic [7:0] sj_o
);

    swap_state_e state_q, state_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [7:0]  si_q, si_d;
    logic [7:0]  sj_q, sj_d;
    logic [7:0]  w_j_new;

    assign w_j_new = j_i + s_rddata_i + add_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SW_IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        case (state_q)
            SW_IDLE: begin
                if (start_i) begin
                    i_d     = i_addr_i;
                    state_d = SW_RDI;
                end
            end
            SW_RDI:  state_d = SW_RDJ;
            SW_RDJ: begin
                si_d    = s_rddata_i;
                j_d     = w_j_new;
                state_d = SW_WRJ;
            end
            // Both reads complete before either write, so i==j leaves S unchanged.
            SW_WRJ: begin
                sj_d    = s_rddata_i;
                state_d = SW_WRI;
            end
            SW_WRI:  state_d = SW_IDLE;
            default: state_d = SW_IDLE;
        endcase
    end

    always_comb begin
        s_addr_o   = 8'd0;
        s_wrdata_o = 8'd0;
        s_wren_o   = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            SW_RDI: s_addr_o = i_q;
            SW_RDJ: s_addr_o = w_j_new;
            SW_WRJ: begin
                s_addr_o   = j_q;
                s_wrdata_o = si_q;
                s_wren_o   = 1'b1;
            end
            SW_WRI: begin
                s_addr_o   = i_q;
                s_wrdata_o = sj_q;
                s_wren_o   = 1'b1;
                done_o     = 1'b1;
            end
            default: ;
        endcase
    end

    assign j_o  = j_q;
    assign si_o = si_q;
    assign sj_o = sj_q;

endmodule
`default_nettype wire

// File: rtl/arc4_encrypt.sv
`default_nettype none
// ============================================================================
// Module      : arc4_encrypt
// Description : ARC4 encryption of a length-prefixed buffer using external memories.
// Revision    : 1.0
// ============================================================================
module arc4_encrypt
    import arc4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic        rdy_o,
    input  logic [23:0] key_i,
    output logic [7:0]  s_addr_o,
    output logic [7:0]  s_wrdata_o,
    output logic        s_wren_o,
    input  logic [7:0]  s_rddata_i,
    output logic [7:0]  pt_addr_o,
    input  logic [7:0]  pt_rddata_i,
    output logic [7:0]  ct_addr_o,
    output logic [7:0]  ct_wrdata_o,
    output logic        ct_wren_o
);

    arc4_state_e       state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [1:0]        kidx_q, kidx_d;
    logic [23:0]       key_q, key_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        pad_addr_q, pad_addr_d;

    logic       w_sw_start;
    logic [7:0] w_sw_i;
    logic [7:0] w_sw_add;
    logic [7:0] w_sw_addr;
    logic [7:0] w_sw_wrdata;
    logic       w_sw_wren;
    logic       w_sw_done;
    logic [7:0] w_sw_j;
    logic [7:0] w_sw_si;
    logic [7:0] w_sw_sj;
    logic       w_s_wren;
    logic       w_ct_wren;

    arc4_swap u_swap (
        .clk        (clk),
        .rst        (rst),
        .start_i    (w_sw_start),
        .i_addr_i   (w_sw_i),
        .j_i        (j_q),
        .add_i      (w_sw_add),
        .s_rddata_i (s_rddata_i),
        .s_addr_o   (w_sw_addr),
        .s_wrdata_o (w_sw_wrdata),
        .s_wren_o   (w_sw_wren),
        .done_o     (w_sw_done),
        .j_o        (w_sw_j),
        .si_o       (w_sw_si),
        .sj_o       (w_sw_sj)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_START;
            cnt_q      <= '0;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            kidx_q     <= 2'd0;
            key_q      <= 24'd0;
            len_q      <= 8'd0;
            pad_addr_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            kidx_q     <= kidx_d;
            key_q      <= key_d;
            len_q      <= len_d;
            pad_addr_q <= pad_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        i_d        = i_q;
        j_d        = j_q;
        kidx_d     = kidx_q;
        key_d      = key_q;
        len_d      = len_q;
        pad_addr_d = pad_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    key_d   = key_i;
                    cnt_d   = '0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                if (cnt_q[7:0] == 8'(MEM_DEPTH - 1)) begin
                    cnt_d   = '0;
                    j_d     = 8'd0;
                    kidx_d  = 2'd0;
                    phase_d = PH_START;
                    state_d = ST_KSA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_KSA: begin
                if (phase_q == PH_START) begin
                    phase_d = PH_WAIT;
                end else if (w_sw_done) begin
                    j_d     = w_sw_j;
                    phase_d = PH_START;
                    kidx_d  = (kidx_q == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx_q + 2'd1;
                    if (cnt_q[7:0] == 8'(MEM_DEPTH - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_LEN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_LEN: begin
                if (phase_q == PH_START) begin
                    phase_d = PH_WAIT;
                end else begin
                    len_d   = pt_rddata_i;
                    phase_d = PH_START;
                    if (pt_rddata_i == 8'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        i_d     = 8'd0;
                        j_d     = 8'd0;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_PRGA;
                    end
                end
            end
            ST_PRGA: begin
                case (phase_q)
                    PH_START: begin
                        i_d     = i_q + 8'd1;
                        phase_d = PH_WAIT;
                    end
                    PH_WAIT: begin
                        // After the swap S[i]+S[j] is the same sum as before it.
                        if (w_sw_done) begin
                            j_d        = w_sw_j;
                            pad_addr_d = w_sw_si + w_sw_sj;
                            phase_d    = PH_PAD;
                        end
                    end
                    PH_PAD:   phase_d = PH_WRITE;
                    default: begin
                        phase_d = PH_START;
                        if (cnt_q == {1'b0, len_q}) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                endcase
            end
            ST_DONE: begin
                cnt_d   = '0;
                i_d     = 8'd0;
                j_d     = 8'd0;
                phase_d = PH_START;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdy_o       = 1'b0;
        s_addr_o    = 8'd0;
        s_wrdata_o  = 8'd0;
        w_s_wren    = 1'b0;
        pt_addr_o   = 8'd0;
        ct_addr_o   = 8'd0;
        ct_wrdata_o = 8'd0;
        w_ct_wren   = 1'b0;
        w_sw_start  = 1'b0;
        w_sw_i      = 8'd0;
        w_sw_add    = 8'd0;
        case (state_q)
            ST_IDLE: rdy_o = 1'b1;
            ST_INIT: begin
                s_addr_o   = cnt_q[7:0];
                s_wrdata_o = cnt_q[7:0];
                w_s_wren   = 1'b1;
            end
            ST_KSA: begin
                w_sw_start = (phase_q == PH_START);
                w_sw_i     = cnt_q[7:0];
                w_sw_add   = key_byte(key_q, kidx_q);
                s_addr_o   = w_sw_addr;
                s_wrdata_o = w_sw_wrdata;
                w_s_wren   = w_sw_wren;
            end
            ST_LEN: begin
                if (phase_q == PH_WAIT) begin
                    ct_wrdata_o = pt_rddata_i;
                    w_ct_wren   = 1'b1;
                end
            end
            ST_PRGA: begin
                w_sw_start = (phase_q == PH_START);
                w_sw_i     = i_q + 8'd1;
                if (phase_q == PH_PAD) begin
                    s_addr_o  = pad_addr_q;
                    pt_addr_o = cnt_q[7:0];
                end else begin
                    s_addr_o   = w_sw_addr;
                    s_wrdata_o = w_sw_wrdata;
                    w_s_wren   = w_sw_wren;
                end
                if (phase_q == PH_WRITE) begin
                    ct_addr_o   = cnt_q[7:0];
                    ct_wrdata_o = pt_rddata_i ^ s_rddata_i;
                    w_ct_wren   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reset wins over any write issued in the same cycle.
    assign s_wren_o  = w_s_wren  & ~rst;
    assign ct_wren_o = w_ct_wren & ~rst;

endmodule
`default_nettype wire
